change_dispenser: RTL

- Downstream of the vending control FSM; consumes its end-of-transaction result (sum_money, price) and pays out change as a sequence of single coins to a coin hopper.
- Greedy selection 20/10/5 against per-denomination stock counters; one coin per valid/ack handshake.
- Reports the amount actually paid, a short-change flag, an underpay flag and live stock levels.

---
 rtl/vending_pkg.sv | 38 +++
 rtl/change_coin_select.sv | 38 +++
 rtl/change_dispenser.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared types and helpers for the change dispenser.
// Holds the payout FSM state encoding, the coin denomination encoding as seen
// by the hopper (0 = none, 1 = 5, 2 = 10, 3 = 20) and the value of each coin.
package vending_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StSelect,
    StDispense,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    CoinNone = 2'd0,
    Coin5    = 2'd1,
    Coin10   = 2'd2,
    Coin20   = 2'd3
  } coin_e;

  localparam int unsigned Value5  = 5;
  localparam int unsigned Value10 = 10;
  localparam int unsigned Value20 = 20;

  // Monetary value of a denomination code; CoinNone is worth nothing.
  function automatic int unsigned deno_value(coin_e deno);
    int unsigned value;
    value = 0;
    case (deno)
      Coin5:   value = Value5;
      Coin10:  value = Value10;
      Coin20:  value = Value20;
      default: value = 0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin picker (purely combinational).
// Picks the largest denomination that both fits in the remaining change and
// still has stock. found_o is low when nothing qualifies, which includes a
// zero remainder and a remainder smaller than the smallest coin in stock.
//   remaining_i             change still owed
//   stock_5_i/10_i/20_i     current stock per denomination
//   deno_o                  chosen denomination (CoinNone if none)
//   found_o                 a denomination was chosen
module change_coin_select
  import vending_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned STOCK_W = 8
) (
  input  logic [W-1:0]       remaining_i,
  input  logic [STOCK_W-1:0] stock_5_i,
  input  logic [STOCK_W-1:0] stock_10_i,
  input  logic [STOCK_W-1:0] stock_20_i,
  output coin_e              deno_o,
  output logic               found_o
);

  always_comb begin
    deno_o  = CoinNone;
    found_o = 1'b0;
    if (remaining_i >= W'(Value20) && stock_20_i != '0) begin
      deno_o  = Coin20;
      found_o = 1'b1;
    end else if (remaining_i >= W'(Value10) && stock_10_i != '0) begin
      deno_o  = Coin10;
      found_o = 1'b1;
    end else if (remaining_i >= W'(Value5) && stock_5_i != '0) begin
      deno_o  = Coin5;
      found_o = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: takes the end-of-transaction result (sum_money, price)
// and pays the difference as single coins to a hopper, greedy 20/10/5,
// one coin per coin_valid/coin_ack handshake.
//   clk, reset          clock; asynchronous active-high reset
//   req_valid/req_ready start request (ready only when idle)
//   sum_money, price    sampled on the accept edge
//   coin_valid/deno/ack coin handshake to the hopper
//   refill, refill_cnt  reload all stocks (idle only, request has priority)
//   busy                not idle
//   change_done         one-cycle pulse at end of payout
//   change_total        value paid this transaction
//   short_change        change left unpaid
//   underpay            price exceeded sum_money
//   stock_5/10/20       live stock levels
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned         W          = 8,
  parameter int unsigned         STOCK_W    = 8,
  parameter logic [STOCK_W-1:0]  INIT_STOCK = 8'd10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [W-1:0]       sum_money,
  input  logic [W-1:0]       price,
  output logic               coin_valid,
  output logic [1:0]         coin_deno,
  input  logic               coin_ack,
  input  logic               refill,
  input  logic [STOCK_W-1:0] refill_cnt,
  output logic               busy,
  output logic               change_done,
  output logic [W-1:0]       change_total,
  output logic               short_change,
  output logic               underpay,
  output logic [STOCK_W-1:0] stock_5,
  output logic [STOCK_W-1:0] stock_10,
  output logic [STOCK_W-1:0] stock_20
);

  state_e             state_q, state_d;
  logic [W-1:0]       sum_q, sum_d;
  logic [W-1:0]       price_q, price_d;
  logic [W-1:0]       remaining_q, remaining_d;
  logic               coin_valid_q, coin_valid_d;
  coin_e              coin_deno_q, coin_deno_d;
  logic               change_done_q, change_done_d;
  logic [W-1:0]       change_total_q, change_total_d;
  logic               short_change_q, short_change_d;
  logic               underpay_q, underpay_d;
  logic [STOCK_W-1:0] stock_5_q, stock_5_d;
  logic [STOCK_W-1:0] stock_10_q, stock_10_d;
  logic [STOCK_W-1:0] stock_20_q, stock_20_d;

  coin_e              sel_deno;
  logic               sel_found;
  logic [W-1:0]       coin_value;

  change_coin_select #(
    .W       (W),
    .STOCK_W (STOCK_W)
  ) u_select (
    .remaining_i (remaining_q),
    .stock_5_i   (stock_5_q),
    .stock_10_i  (stock_10_q),
    .stock_20_i  (stock_20_q),
    .deno_o      (sel_deno),
    .found_o     (sel_found)
  );

  always_comb begin
    state_d        = state_q;
    sum_d          = sum_q;
    price_d        = price_q;
    remaining_d    = remaining_q;
    coin_valid_d   = coin_valid_q;
    coin_deno_d    = coin_deno_q;
    change_done_d  = 1'b0;
    change_total_d = change_total_q;
    short_change_d = short_change_q;
    underpay_d     = underpay_q;
    stock_5_d      = stock_5_q;
    stock_10_d     = stock_10_q;
    stock_20_d     = stock_20_q;
    coin_value     = W'(deno_value(coin_deno_q));

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          sum_d          = sum_money;
          price_d        = price;
          change_total_d = '0;
          short_change_d = 1'b0;
          underpay_d     = 1'b0;
          state_d        = StCalc;
        end else if (refill) begin
          stock_5_d  = refill_cnt;
          stock_10_d = refill_cnt;
          stock_20_d = refill_cnt;
        end
      end
      StCalc: begin
        if (price_q > sum_q) begin
          underpay_d  = 1'b1;
          remaining_d = '0;
        end else begin
          remaining_d = sum_q - price_q;
        end
        state_d = StSelect;
      end
      StSelect: begin
        if (remaining_q == '0) begin
          change_done_d = 1'b1;
          state_d       = StDone;
        end else if (!sel_found) begin
          short_change_d = 1'b1;
          change_done_d  = 1'b1;
          state_d        = StDone;
        end else begin
          coin_deno_d  = sel_deno;
          coin_valid_d = 1'b1;
          state_d      = StDispense;
        end
      end
      StDispense: begin
        if (coin_valid_q && coin_ack) begin
          // Selector guaranteed coin_value <= remaining and stock > 0.
          remaining_d    = remaining_q - coin_value;
          change_total_d = change_total_q + coin_value;
          case (coin_deno_q)
            Coin5:   if (stock_5_q != '0) stock_5_d = stock_5_q - 1'b1;
            Coin10:  if (stock_10_q != '0) stock_10_d = stock_10_q - 1'b1;
            Coin20:  if (stock_20_q != '0) stock_20_d = stock_20_q - 1'b1;
            default: ;
          endcase
          coin_valid_d = 1'b0;
          coin_deno_d  = CoinNone;
          state_d      = StSelect;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      sum_q          <= '0;
      price_q        <= '0;
      remaining_q    <= '0;
      coin_valid_q   <= 1'b0;
      coin_deno_q    <= CoinNone;
      change_done_q  <= 1'b0;
      change_total_q <= '0;
      short_change_q <= 1'b0;
      underpay_q     <= 1'b0;
      stock_5_q      <= INIT_STOCK;
      stock_10_q     <= INIT_STOCK;
      stock_20_q     <= INIT_STOCK;
    end else begin
      state_q        <= state_d;
      sum_q          <= sum_d;
      price_q        <= price_d;
      remaining_q    <= remaining_d;
      coin_valid_q   <= coin_valid_d;
      coin_deno_q    <= coin_deno_d;
      change_done_q  <= change_done_d;
      change_total_q <= change_total_d;
      short_change_q <= short_change_d;
      underpay_q     <= underpay_d;
      stock_5_q      <= stock_5_d;
      stock_10_q     <= stock_10_d;
      stock_20_q     <= stock_20_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign coin_valid   = coin_valid_q;
  assign coin_deno    = coin_deno_q;
  assign change_done  = change_done_q;
  assign change_total = change_total_q;
  assign short_change = short_change_q;
  assign underpay     = underpay_q;
  assign stock_5      = stock_5_q;
  assign stock_10     = stock_10_q;
  assign stock_20     = stock_20_q;

endmodule
